bus_dev_port: RTL and testbench

- Device-side endpoint placed between one host/agent and one port of the bus generator-and-arbiter (`bs_gnrtr_n_rbtr`). One instance is used per driver index.
- TX path: queues host packets and presents them to the arbiter through `pndng` and `D_pop`. The arbiter consumes each packet with `pop`.
- RX path: captures packets the bus delivers with `push`/`D_push`. It keeps only packets addressed to this device or to broadcast, and buffers them for the host.

---
 rtl/bus_dev_pkg.sv | 14 +
 rtl/sync_fifo_fwft.sv | 48 ++++
 rtl/bus_dev_port.sv | 84 ++++++++
 tb/tb_bus_dev_port.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bus_dev_pkg.sv
// Shared definitions for the bus device port: the destination field layout
// and the default broadcast address.
package bus_dev_pkg;
  localparam int DEST_W    = 8;
  localparam int PKT_MAX_W = 64;
  localparam logic [DEST_W-1:0] BROADCAST_DEF = 8'hFF;

  // The destination is the top DEST_W bits of a w-bit packet. The packet is
  // passed zero-extended to PKT_MAX_W bits.
  function automatic logic [DEST_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                input int unsigned         w);
    return DEST_W'(pkt >> (w - DEST_W));
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO. The head is visible whenever the FIFO is not
// empty. A write is taken when there is space, or when the same cycle's read frees a slot.
module sync_fifo_fwft #(
  parameter  int width = 16,
  parameter  int depth = 8,
  localparam int AW    = $clog2(depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] din,
  input  logic             rd,
  output logic [width-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [width-1:0] mem_q [depth];
  logic             rd_ok, wr_ok;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  assign wptr_d = wptr_q + {{AW{1'b0}}, wr_ok};
  assign rptr_d = rptr_q + {{AW{1'b0}}, rd_ok};

  // Gating the head with empty keeps dout at zero after reset, so the
  // storage array itself never needs to be reset.
  assign dout = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/bus_dev_port.sv
// Device-side endpoint for one arbiter port. TX queues host packets for the
// arbiter. RX keeps only packets addressed to this device or to broadcast.
module bus_dev_port
  import bus_dev_pkg::*;
#(
  parameter int                pckg_sz   = 16,
  parameter int                depth     = 8,
  parameter logic [DEST_W-1:0] id        = 8'd0,
  parameter logic [DEST_W-1:0] broadcast = BROADCAST_DEF,
  localparam int               CW        = $clog2(depth) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  output logic               tx_full,
  output logic [CW-1:0]      tx_count,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic               tx_ovf,
  output logic               tx_udf,
  output logic [7:0]         rx_drop_cnt
);
  typedef logic [pckg_sz-1:0] pkt_t;

  logic             tx_empty, rx_empty, rx_full;
  logic [CW-1:0]    rx_cnt_unused;
  logic [PKT_MAX_W-1:0] d_push_ext;
  logic [DEST_W-1:0]    rx_dest;
  logic             rx_match, rx_drop;
  logic             tx_ovf_q, tx_ovf_d, tx_udf_q, tx_udf_d;
  logic [7:0]       drop_q, drop_d;
  pkt_t             tx_head, rx_head;

  sync_fifo_fwft #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk(clk), .reset(reset),
    .wr(wr_en), .din(wr_data), .rd(pop),
    .dout(tx_head), .empty(tx_empty), .full(tx_full), .count(tx_count)
  );

  sync_fifo_fwft #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk(clk), .reset(reset),
    .wr(rx_match), .din(D_push), .rd(rx_ready),
    .dout(rx_head), .empty(rx_empty), .full(rx_full), .count(rx_cnt_unused)
  );

  assign pndng    = ~tx_empty;
  assign D_pop    = tx_head;
  assign rx_valid = ~rx_empty;
  assign rx_data  = rx_head;

  assign d_push_ext = PKT_MAX_W'(D_push);
  assign rx_dest    = dest_of(d_push_ext, pckg_sz);
  assign rx_match   = push & ((rx_dest == id) | (rx_dest == broadcast));
  assign rx_drop    = rx_match & rx_full & ~rx_ready;

  // A pop against a full FIFO always succeeds, so it always frees the slot
  // that a simultaneous write needs.
  assign tx_ovf_d = tx_ovf_q | (wr_en & tx_full & ~pop);
  assign tx_udf_d = tx_udf_q | (pop & tx_empty);
  assign drop_d   = (rx_drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf_q <= 1'b0;
      tx_udf_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      tx_udf_q <= tx_udf_d;
      drop_q   <= drop_d;
    end
  end

  assign tx_ovf      = tx_ovf_q;
  assign tx_udf      = tx_udf_q;
  assign rx_drop_cnt = drop_q;
endmodule

// File: tb/tb_bus_dev_port.sv
// Scoreboard bench for bus_dev_port: stimulus queues expected packets, and a
// negedge monitor compares every TX pop and RX dequeue against them.
module tb_bus_dev_port;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, pop, push, rx_ready;
  logic [15:0] wr_data, D_push;
  logic        tx_full, pndng, rx_valid, tx_ovf, tx_udf;
  logic [3:0]  tx_count;
  logic [15:0] D_pop, rx_data;
  logic [7:0]  rx_drop_cnt;

  int          n_tot  = 0;
  int          n_pass = 0;
  logic [15:0] txq[$];
  logic [15:0] rxq[$];

  bus_dev_port #(.pckg_sz(16), .depth(8), .id(8'd2), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data),
    .tx_full(tx_full), .tx_count(tx_count),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_ovf(tx_ovf), .tx_udf(tx_udf), .rx_drop_cnt(rx_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic unexpected(input string nm, input logic [15:0] act);
    n_tot++;
    $display("FAIL %s: got %0h, expected nothing queued", nm, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (pop && pndng) begin
        if (txq.size() == 0) unexpected("tx_pop_unexpected", D_pop);
        else chk("tx_pkt", 32'(D_pop), 32'(txq.pop_front()));
      end
      if (rx_ready && rx_valid) begin
        if (rxq.size() == 0) unexpected("rx_deq_unexpected", rx_data);
        else chk("rx_pkt", 32'(rx_data), 32'(rxq.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0; wr_en = 1'b0; pop = 1'b0; push = 1'b0; rx_ready = 1'b0;
    wr_data = '0; D_push = '0;
    tick(); tick();
    chk("rst_pndng", 32'(pndng), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_D_pop", 32'(D_pop), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    reset = 1'b1;
    tick();
    chk("idle_pndng", 32'(pndng), 0);
    chk("idle_tx_count", 32'(tx_count), 0);
    chk("idle_tx_full", 32'(tx_full), 0);
    chk("idle_flags", 32'({tx_ovf, tx_udf}), 0);
    chk("idle_drop", 32'(rx_drop_cnt), 0);
    pop = 1'b1; tick(); pop = 1'b0;
    chk("udf_set", 32'(tx_udf), 1);
    chk("udf_count", 32'(tx_count), 0);

    // TX ordering, full and overflow
    do_reset();
    chk("post_rst_udf", 32'(tx_udf), 0);
    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_data = 16'h0100 + 16'(i); txq.push_back(wr_data); tick();
    end
    chk("tx_full8", 32'(tx_full), 1);
    chk("tx_count8", 32'(tx_count), 8);
    chk("tx_ovf_before", 32'(tx_ovf), 0);
    wr_data = 16'h0109; tick(); wr_en = 1'b0;
    chk("tx_ovf_after", 32'(tx_ovf), 1);
    chk("tx_count_ovf", 32'(tx_count), 8);
    pop = 1'b1; repeat (8) tick(); pop = 1'b0;
    chk("tx_drained", 32'(pndng), 0);
    chk("tx_no_udf", 32'(tx_udf), 0);

    // full with simultaneous write and pop
    do_reset();
    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_data = 16'h0200 + 16'(i); txq.push_back(wr_data); tick();
    end
    wr_data = 16'hAAAA; pop = 1'b1; txq.push_back(16'hAAAA); tick();
    wr_en = 1'b0; pop = 1'b0;
    chk("sim_ovf", 32'(tx_ovf), 0);
    chk("sim_count", 32'(tx_count), 8);
    pop = 1'b1; repeat (8) tick(); pop = 1'b0;
    chk("sim_drained", 32'(pndng), 0);

    // RX filter
    do_reset();
    push = 1'b1;
    D_push = 16'h02CD; rxq.push_back(D_push); tick();
    D_push = 16'h03CD; tick();
    D_push = 16'hFF11; rxq.push_back(D_push); tick();
    push = 1'b0;
    chk("filt_valid", 32'(rx_valid), 1);
    rx_ready = 1'b1; repeat (2) tick(); rx_ready = 1'b0;
    chk("filt_empty", 32'(rx_valid), 0);
    chk("filt_drop", 32'(rx_drop_cnt), 0);

    // RX overflow and full-with-dequeue
    do_reset();
    push = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      D_push = 16'h0200 + 16'(i);
      if (i <= 8) rxq.push_back(D_push);
      tick();
    end
    push = 1'b0;
    chk("rxovf_drop", 32'(rx_drop_cnt), 2);
    chk("rxovf_valid", 32'(rx_valid), 1);
    push = 1'b1; rx_ready = 1'b1; D_push = 16'h02AB; rxq.push_back(D_push); tick();
    push = 1'b0;
    chk("rxovf_drop_same", 32'(rx_drop_cnt), 2);
    repeat (8) tick(); rx_ready = 1'b0;
    chk("rxovf_drained", 32'(rx_valid), 0);

    // asynchronous reset mid-traffic
    do_reset();
    wr_en = 1'b1; push = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wr_data = 16'h0500 + 16'(i); D_push = 16'h0230 + 16'(i);
      if (i == 4) push = 1'b0;
      tick();
    end
    wr_en = 1'b0;
    chk("pre_ar_count", 32'(tx_count), 5);
    chk("pre_ar_rx", 32'(rx_valid), 1);
    reset = 1'b0; #1;
    chk("ar_pndng", 32'(pndng), 0);
    chk("ar_rx_valid", 32'(rx_valid), 0);
    chk("ar_count", 32'(tx_count), 0);
    tick(); reset = 1'b1; tick();
    wr_en = 1'b1; wr_data = 16'h0777; txq.push_back(wr_data); tick(); wr_en = 1'b0;
    chk("ar_first_pndng", 32'(pndng), 1);
    chk("ar_first_data", 32'(D_pop), 32'h0777);
    pop = 1'b1; tick(); pop = 1'b0;
    tick();

    chk("txq_consumed", 32'(txq.size()), 0);
    chk("rxq_consumed", 32'(rxq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
